// File: rtl/relu_maxpool_pkg.sv
// ---------------------------------------------------------------------------
// relu_maxpool_pkg
// Shared constants for the ReLU + 2x2 max-pool stage that sits behind
// top_conv: activation widths shared with the neighbouring layers, the
// default feature-map size and the default requantization shift.
// ---------------------------------------------------------------------------
package relu_maxpool_pkg;

    // Signed conv result width (top_conv oY) and next-layer activation width
    localparam int ACT_BW_IN  = 16;
    localparam int ACT_BW_OUT = 8;

    // Default input feature-map dimensions (both must be even)
    localparam int FMAP_W     = 28;
    localparam int FMAP_H     = 28;

    // Default requantization right shift
    localparam int REQ_SHIFT  = 4;

endpackage

// File: rtl/relu_maxpool_if.sv
// ---------------------------------------------------------------------------
// relu_maxpool_if
// Streaming bus between the conv producer and the pooling stage, plus the
// pooled output stream.
//   iY     : signed conv result, raster order
//   iValid : iY valid this cycle
//   iClear : synchronous frame realign
//   oP     : pooled, requantized activation (never negative)
//   oValid : one-cycle pulse per pooled pixel
//   oLast  : final pooled pixel of a frame (only with oValid)
// Modports: master drives the input stream and observes the output,
// slave is the pooling stage.
// ---------------------------------------------------------------------------
interface relu_maxpool_if
    import relu_maxpool_pkg::*;
#(
    parameter int BW_IN  = ACT_BW_IN,
    parameter int BW_OUT = ACT_BW_OUT
);

    logic [BW_IN-1:0]  iY;
    logic              iValid;
    logic              iClear;
    logic [BW_OUT-1:0] oP;
    logic              oValid;
    logic              oLast;

    modport master (
        output iY,
        output iValid,
        output iClear,
        input  oP,
        input  oValid,
        input  oLast
    );

    modport slave (
        input  iY,
        input  iValid,
        input  iClear,
        output oP,
        output oValid,
        output oLast
    );

endinterface

// File: rtl/relu_maxpool_pool_line_buf.sv
// ---------------------------------------------------------------------------
// pool_line_buf
// One row of horizontal pair maxima (IMG_W/2 entries). Single address port:
// writes happen on even input rows and reads on odd rows, so a read and a
// write never target the buffer in the same cycle. Kept as its own module so
// it can be replaced by a single-port RAM macro.
//   clk   : clock, rising edge
//   we    : write enable
//   addr  : entry index (shared by read and write)
//   wdata : data to write
//   rdata : combinational read of entry addr
// Contents are intentionally not reset: every entry is rewritten on an even
// row before the following odd row reads it.
// ---------------------------------------------------------------------------
module pool_line_buf #(
    parameter int DEPTH = 14,
    parameter int DW    = 15,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
)(
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_r [0:DEPTH-1];

    // Storage write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    // Combinational read port
    always_comb begin
        rdata = mem_r[addr];
    end

endmodule

// File: rtl/relu_maxpool.sv
// ---------------------------------------------------------------------------
// relu_maxpool
// ReLU, 2x2/stride-2 max pooling and requantization of one raster-ordered
// conv output channel. Output is a raster-ordered pooled map, one cycle of
// latency, with a last flag on the final pooled pixel of each frame.
//   iCLK  : clock, rising edge
//   iRSTn : asynchronous active-low reset
//   bus   : slave side of relu_maxpool_if (iY/iValid/iClear in,
//           oP/oValid/oLast out)
// iClear acts as the synchronous soft reset of the position counters and
// the horizontal hold register; it wins over a coincident iValid.
// ---------------------------------------------------------------------------
module relu_maxpool
    import relu_maxpool_pkg::*;
#(
    parameter int BW_IN  = ACT_BW_IN,
    parameter int BW_OUT = ACT_BW_OUT,
    parameter int IMG_W  = FMAP_W,
    parameter int IMG_H  = FMAP_H,
    parameter int SHIFT  = REQ_SHIFT
)(
    input  logic          iCLK,
    input  logic          iRSTn,
    relu_maxpool_if.slave bus
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int AW = CW - 1;          // IMG_W is even, so col>>1 fits

    localparam logic [CW-1:0]     COL_LAST  = CW'(IMG_W - 1);
    localparam logic [RW-1:0]     ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [CW-1:0]     COL_ONE   = CW'(1);
    localparam logic [RW-1:0]     ROW_ONE   = RW'(1);
    localparam logic [BW_OUT-1:0] OUT_MAX   = {1'b0, {(BW_OUT-1){1'b1}}};
    localparam logic [BW_IN-2:0]  SAT_LIMIT = (BW_IN-1)'(OUT_MAX);

    // Unsigned maximum of two post-ReLU values
    function automatic logic [BW_IN-2:0] umax(input logic [BW_IN-2:0] a,
                                              input logic [BW_IN-2:0] b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

    logic [CW-1:0]     col_r;
    logic [RW-1:0]     row_r;
    logic [BW_IN-2:0]  hold_r;
    logic [BW_OUT-1:0] op_r;
    logic              ovalid_r;
    logic              olast_r;

    logic              accept_s;
    logic              pool_s;
    logic              last_s;
    logic              lb_we_s;
    logic [AW-1:0]     lb_addr_s;
    logic [BW_IN-2:0]  lb_rd_s;
    logic [BW_IN-2:0]  relu_s;
    logic [BW_IN-2:0]  h_s;
    logic [BW_IN-2:0]  m_s;
    logic [BW_IN-2:0]  q_s;
    logic [BW_OUT-1:0] p_s;

    // Position decode: which action the current sample triggers
    always_comb begin
        accept_s  = 1'b0;
        lb_we_s   = 1'b0;
        pool_s    = 1'b0;
        last_s    = 1'b0;
        lb_addr_s = col_r[CW-1:1];
        accept_s  = bus.iValid & ~bus.iClear;
        // Odd column closes a horizontal pair; the row parity picks store vs. pool
        lb_we_s   = accept_s & col_r[0] & ~row_r[0];
        pool_s    = accept_s & col_r[0] & row_r[0];
        last_s    = (row_r == ROW_LAST) && (col_r == COL_LAST);
    end

    // Datapath: ReLU, pair max, window max, shift and saturate
    always_comb begin
        relu_s = {(BW_IN-1){1'b0}};
        h_s    = {(BW_IN-1){1'b0}};
        m_s    = {(BW_IN-1){1'b0}};
        q_s    = {(BW_IN-1){1'b0}};
        p_s    = {BW_OUT{1'b0}};
        // Dropping the sign bit after clamping negatives leaves BW_IN-1 bits
        if (bus.iY[BW_IN-1]) begin
            relu_s = {(BW_IN-1){1'b0}};
        end else begin
            relu_s = bus.iY[BW_IN-2:0];
        end
        h_s = umax(hold_r, relu_s);
        m_s = umax(h_s, lb_rd_s);
        q_s = m_s >> SHIFT;
        if (q_s > SAT_LIMIT) begin
            p_s = OUT_MAX;
        end else begin
            p_s = q_s[BW_OUT-1:0];
        end
    end

    pool_line_buf #(
        .DEPTH (IMG_W / 2),
        .DW    (BW_IN - 1)
    ) u_line_buf (
        .clk   (iCLK),
        .we    (lb_we_s),
        .addr  (lb_addr_s),
        .wdata (h_s),
        .rdata (lb_rd_s)
    );

    // Raster position counters; advance only on accepted samples
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            col_r <= {CW{1'b0}};
            row_r <= {RW{1'b0}};
        end else if (bus.iClear) begin
            col_r <= {CW{1'b0}};
            row_r <= {RW{1'b0}};
        end else if (bus.iValid) begin
            if (col_r == COL_LAST) begin
                col_r <= {CW{1'b0}};
                if (row_r == ROW_LAST) begin
                    row_r <= {RW{1'b0}};
                end else begin
                    row_r <= row_r + ROW_ONE;
                end
            end else begin
                col_r <= col_r + COL_ONE;
            end
        end else begin
            col_r <= col_r;
            row_r <= row_r;
        end
    end

    // Left element of each horizontal pair
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            hold_r <= {(BW_IN-1){1'b0}};
        end else if (bus.iClear) begin
            hold_r <= {(BW_IN-1){1'b0}};
        end else if (accept_s && !col_r[0]) begin
            hold_r <= relu_s;
        end else begin
            hold_r <= hold_r;
        end
    end

    // Output registers; oP holds its last value between pulses
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            op_r     <= {BW_OUT{1'b0}};
            ovalid_r <= 1'b0;
            olast_r  <= 1'b0;
        end else if (pool_s) begin
            op_r     <= p_s;
            ovalid_r <= 1'b1;
            olast_r  <= last_s;
        end else begin
            op_r     <= op_r;
            ovalid_r <= 1'b0;
            olast_r  <= 1'b0;
        end
    end

    assign bus.oP     = op_r;
    assign bus.oValid = ovalid_r;
    assign bus.oLast  = olast_r;

endmodule

// File: tb/tb_relu_maxpool.sv
// ---------------------------------------------------------------------------
// tb_relu_maxpool
// Self-checking bench for relu_maxpool at default parameters. A frame is
// built in an array first; every accepted sample advances a raster index in
// the bench, and whenever that index lands on the bottom-right pixel of a
// 2x2 window the expected output is taken directly from the frame array.
// ---------------------------------------------------------------------------
module tb_relu_maxpool;
    import relu_maxpool_pkg::*;

    localparam int W   = FMAP_W;
    localparam int H   = FMAP_H;
    localparam int SH  = REQ_SHIFT;
    localparam int NPX = W * H;
    localparam int NOUT = (W / 2) * (H / 2);

    logic iCLK  = 1'b0;
    logic iRSTn = 1'b0;

    always #5 iCLK = ~iCLK;

    relu_maxpool_if #(.BW_IN(ACT_BW_IN), .BW_OUT(ACT_BW_OUT)) bus ();

    relu_maxpool #(
        .BW_IN  (ACT_BW_IN),
        .BW_OUT (ACT_BW_OUT),
        .IMG_W  (W),
        .IMG_H  (H),
        .SHIFT  (SH)
    ) dut (
        .iCLK  (iCLK),
        .iRSTn (iRSTn),
        .bus   (bus)
    );

    typedef struct {
        int kind;        // 0 ramp, 1 constant
        int value;       // constant value
        int bub;         // 0 none, 1 toggle, 2 random
        int exp_first;
        int exp_last;
    } vec_t;

    vec_t tbl [9];

    int checks   = 0;
    int failures = 0;
    int frame [H][W];
    int k;              // raster index of the next accepted sample
    int exp_p;          // value oP must hold between pulses
    int n_out, n_last, first_p, last_p, last_on_final;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Expected pooled value of the window whose bottom-right pixel is (r,c)
    function automatic int pool_ref(int r, int c);
        int m = 0;
        int q;
        for (int dr = 0; dr < 2; dr++) begin
            for (int dc = 0; dc < 2; dc++) begin
                if (frame[r-dr][c-dc] > m) m = frame[r-dr][c-dc];
            end
        end
        q = m / (1 << SH);
        if (q > 127) q = 127;
        return q;
    endfunction

    task automatic fill(input int kind, input int value);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                case (kind)
                    0: frame[r][c] = r * W + c;
                    1: frame[r][c] = value;
                    2: frame[r][c] = int'($urandom_range(65535, 0)) - 32768;
                    default: frame[r][c] = int'($urandom_range(3300, 0)) - 300;
                endcase
            end
        end
    endtask

    task automatic reset_counts();
        n_out = 0; n_last = 0; first_p = -1; last_p = -1; last_on_final = 0;
    endtask

    // One clock: drive at negedge, capture at posedge, check 1 time unit later
    task automatic step(input bit v, input bit clr, input int y);
        bit ev = 1'b0;
        bit el = 1'b0;
        int ep = 0;
        int idx = k;
        @(negedge iCLK);
        bus.iValid = v;
        bus.iClear = clr;
        bus.iY     = 16'(y);
        @(posedge iCLK);
        #1;
        if (clr) begin
            k = 0;
        end else if (v) begin
            if ((idx / W) % 2 == 1 && (idx % W) % 2 == 1) begin
                ev = 1'b1;
                ep = pool_ref(idx / W, idx % W);
                el = (idx == NPX - 1);
            end
            k = (idx + 1) % NPX;
        end
        check($sformatf("oValid@%0d", idx), bus.oValid, ev);
        if (ev) begin
            check($sformatf("oP@%0d", idx), bus.oP, ep);
            check($sformatf("oLast@%0d", idx), bus.oLast, el);
            exp_p = ep;
        end else begin
            check($sformatf("oP_hold@%0d", idx), bus.oP, exp_p);
            check($sformatf("oLast_idle@%0d", idx), bus.oLast, 0);
        end
        if (bus.oValid === 1'b1) begin
            if (n_out == 0) first_p = int'(bus.oP);
            last_p = int'(bus.oP);
            n_out++;
            if (bus.oLast === 1'b1) n_last++;
            last_on_final = int'(bus.oLast);
        end
    endtask

    task automatic send(input int nsamp, input int bub);
        for (int i = 0; i < nsamp; i++) begin
            if (bub == 1 || (bub == 2 && $urandom_range(3, 0) == 0)) begin
                step(1'b0, 1'b0, int'($urandom_range(65535, 0)) - 32768);
            end
            step(1'b1, 1'b0, frame[i / W][i % W]);
        end
    endtask

    task automatic frame_summary(input string name, input int ef, input int el);
        check({name, "_count"}, n_out, NOUT);
        check({name, "_last_count"}, n_last, 1);
        check({name, "_last_on_final"}, last_on_final, 1);
        check({name, "_first"}, first_p, ef);
        check({name, "_final"}, last_p, el);
    endtask

    initial begin
        tbl[0] = '{0,      0, 0,   1,  48};   // ramp
        tbl[1] = '{1,   -100, 0,   0,   0};   // all negative
        tbl[2] = '{1,  32767, 0, 127, 127};   // saturation
        tbl[3] = '{0,      0, 1,   1,  48};   // ramp with toggling valid
        tbl[4] = '{1,   2031, 0, 126, 126};   // just below saturation
        tbl[5] = '{1,   2032, 0, 127, 127};   // exactly at the limit
        tbl[6] = '{1,   2048, 0, 127, 127};   // one step over the limit
        tbl[7] = '{1,      0, 0,   0,   0};
        tbl[8] = '{1,     16, 2,   1,   1};   // smallest value surviving the shift

        bus.iY = 16'sd0; bus.iValid = 1'b0; bus.iClear = 1'b0;
        k = 0; exp_p = 0;
        #1;
        check("reset_oP", bus.oP, 0);
        check("reset_oValid", bus.oValid, 0);
        check("reset_oLast", bus.oLast, 0);
        repeat (3) @(negedge iCLK);
        iRSTn = 1'b1;

        // Table frames, sent back to back without gaps
        for (int t = 0; t < 9; t++) begin
            fill(tbl[t].kind, tbl[t].value);
            reset_counts();
            send(NPX, tbl[t].bub);
            frame_summary($sformatf("tbl%0d", t), tbl[t].exp_first, tbl[t].exp_last);
        end

        // Randomized frames: full-range and mostly non-saturating values
        for (int t = 0; t < 2; t++) begin
            fill(2 + t, 0);
            reset_counts();
            send(NPX, 2 * t);
            check($sformatf("rnd%0d_count", t), n_out, NOUT);
            check($sformatf("rnd%0d_last_count", t), n_last, 1);
        end

        // Reset in the middle of a frame
        fill(0, 0);
        send(300, 0);
        @(negedge iCLK);
        bus.iValid = 1'b0;
        #2 iRSTn = 1'b0;
        #1;
        check("midrst_oP", bus.oP, 0);
        check("midrst_oValid", bus.oValid, 0);
        check("midrst_oLast", bus.oLast, 0);
        k = 0; exp_p = 0;
        repeat (2) @(negedge iCLK);
        iRSTn = 1'b1;
        reset_counts();
        send(NPX, 0);
        frame_summary("after_reset", 1, 48);

        // iClear together with a valid sample drops that sample
        send(50, 0);
        step(1'b1, 1'b1, frame[50 / W][50 % W]);
        reset_counts();
        send(NPX, 0);
        frame_summary("after_clear", 1, 48);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
